// File: rtl/sqrt_ctrl_pkg.sv
// rtl/sqrt_ctrl_pkg.sv - states, ALU op codes and register map for the sqrt controller
package sqrt_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ERR,
    LD_N,
    LD_ODD,
    LD_CNT,
    LD_ONE,
    LD_TWO,
    LD_ZERO,
    SUB,
    INC,
    ODD,
    OUT,
    DONE
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

  // Plain ints so the top can cast them to its own address width
  localparam int REG_REM  = 0;
  localparam int REG_ODD  = 1;
  localparam int REG_CNT  = 2;
  localparam int REG_ONE  = 3;
  localparam int REG_TWO  = 4;
  localparam int REG_ZERO = 7;

endpackage

// File: rtl/sqrt_controller_if.sv
// rtl/sqrt_controller_if.sv - control/flag bundle between the sqrt controller and the datapath
interface sqrt_controller_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
);
  logic                  ie_o;
  logic                  we_o;
  logic                  oe_o;
  logic [ADDR_WIDTH-1:0] addr_wr_o;
  logic [ADDR_WIDTH-1:0] addr_rda_o;
  logic [ADDR_WIDTH-1:0] addr_rdb_o;
  logic [1:0]            alu_op_o;
  logic [DATA_WIDTH-1:0] dp_data_o;
  logic                  negative_i;
  logic                  zero_i;

  modport master (
    output ie_o, we_o, oe_o, addr_wr_o, addr_rda_o, addr_rdb_o, alu_op_o, dp_data_o,
    input  negative_i, zero_i
  );

  modport slave (
    input  ie_o, we_o, oe_o, addr_wr_o, addr_rda_o, addr_rdb_o, alu_op_o, dp_data_o,
    output negative_i, zero_i
  );
endinterface

// File: rtl/sqrt_controller.sv
// rtl/sqrt_controller.sv - sequences the regfile/ALU datapath to compute floor(sqrt(N))
module sqrt_controller
  import sqrt_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] operand_i,
  sqrt_controller_if.master     dp,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] operand_q;
  logic                  sub_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      operand_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start_i)
        operand_q <= operand_i;
    end
  end

  // An exact-square step (zero) is a valid subtraction, not a termination
  assign sub_ok = !dp.negative_i || dp.zero_i;

  always_comb begin
    state_nxt     = state;
    dp.ie_o       = 1'b0;
    dp.we_o       = 1'b0;
    dp.oe_o       = 1'b0;
    dp.addr_wr_o  = '0;
    dp.addr_rda_o = '0;
    dp.addr_rdb_o = '0;
    dp.alu_op_o   = ALU_ADD;
    dp.dp_data_o  = '0;
    busy_o        = (state != IDLE);
    done_o        = 1'b0;
    err_o         = 1'b0;

    case (state)
      IDLE: begin
        if (start_i)
          state_nxt = operand_i[DATA_WIDTH-1] ? ERR : LD_N;
      end
      ERR: begin
        done_o    = 1'b1;
        err_o     = 1'b1;
        state_nxt = IDLE;
      end
      LD_N: begin
        dp.ie_o      = 1'b1;
        dp.we_o      = 1'b1;
        dp.addr_wr_o = ADDR_WIDTH'(REG_REM);
        dp.dp_data_o = operand_q;
        state_nxt    = LD_ODD;
      end
      LD_ODD: begin
        dp.ie_o      = 1'b1;
        dp.we_o      = 1'b1;
        dp.addr_wr_o = ADDR_WIDTH'(REG_ODD);
        dp.dp_data_o = DATA_WIDTH'(1);
        state_nxt    = LD_CNT;
      end
      LD_CNT: begin
        dp.ie_o      = 1'b1;
        dp.we_o      = 1'b1;
        dp.addr_wr_o = ADDR_WIDTH'(REG_CNT);
        state_nxt    = LD_ONE;
      end
      LD_ONE: begin
        dp.ie_o      = 1'b1;
        dp.we_o      = 1'b1;
        dp.addr_wr_o = ADDR_WIDTH'(REG_ONE);
        dp.dp_data_o = DATA_WIDTH'(1);
        state_nxt    = LD_TWO;
      end
      LD_TWO: begin
        dp.ie_o      = 1'b1;
        dp.we_o      = 1'b1;
        dp.addr_wr_o = ADDR_WIDTH'(REG_TWO);
        dp.dp_data_o = DATA_WIDTH'(2);
        state_nxt    = LD_ZERO;
      end
      LD_ZERO: begin
        dp.ie_o      = 1'b1;
        dp.we_o      = 1'b1;
        dp.addr_wr_o = ADDR_WIDTH'(REG_ZERO);
        state_nxt    = SUB;
      end
      SUB: begin
        dp.addr_rda_o = ADDR_WIDTH'(REG_REM);
        dp.addr_rdb_o = ADDR_WIDTH'(REG_ODD);
        dp.alu_op_o   = ALU_SUB;
        dp.addr_wr_o  = ADDR_WIDTH'(REG_REM);
        dp.we_o       = sub_ok;
        state_nxt     = sub_ok ? INC : OUT;
      end
      INC: begin
        dp.addr_rda_o = ADDR_WIDTH'(REG_CNT);
        dp.addr_rdb_o = ADDR_WIDTH'(REG_ONE);
        dp.alu_op_o   = ALU_ADD;
        dp.we_o       = 1'b1;
        dp.addr_wr_o  = ADDR_WIDTH'(REG_CNT);
        state_nxt     = ODD;
      end
      ODD: begin
        dp.addr_rda_o = ADDR_WIDTH'(REG_ODD);
        dp.addr_rdb_o = ADDR_WIDTH'(REG_TWO);
        dp.alu_op_o   = ALU_ADD;
        dp.we_o       = 1'b1;
        dp.addr_wr_o  = ADDR_WIDTH'(REG_ODD);
        state_nxt     = SUB;
      end
      OUT: begin
        // count + 0 passes through the ALU into the output register
        dp.addr_rda_o = ADDR_WIDTH'(REG_CNT);
        dp.addr_rdb_o = ADDR_WIDTH'(REG_ZERO);
        dp.alu_op_o   = ALU_ADD;
        dp.oe_o       = 1'b1;
        state_nxt     = DONE;
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sqrt_controller.sv
// tb/tb_sqrt_controller.sv - directed bench for sqrt_controller with a behavioural datapath
module tb_sqrt_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] operand_i = '0;
  logic        busy_o, done_o, err_o;

  int n_asserts = 0;
  int n_fail = 0;

  sqrt_controller_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dp ();

  sqrt_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .operand_i(operand_i),
    .dp       (dp),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  // Datapath: 8x32 register file, combinational ALU, output register
  logic [31:0] rf [8];
  logic [31:0] alu_a, alu_b, alu_y;
  logic [31:0] dp_out = '0;

  assign alu_a = rf[dp.addr_rda_o];
  assign alu_b = rf[dp.addr_rdb_o];
  assign alu_y = (dp.alu_op_o == 2'b01) ? (alu_a - alu_b) :
                 (dp.alu_op_o == 2'b00) ? (alu_a + alu_b) : 32'h0;
  assign dp.negative_i = alu_y[31];
  assign dp.zero_i     = (alu_y == 32'h0);

  always @(posedge clk) begin
    if (dp.we_o) rf[dp.addr_wr_o] <= dp.ie_o ? dp.dp_data_o : alu_y;
    if (dp.oe_o) dp_out <= alu_y;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand, follow it to done_o and check result, latency, busy and SUB write gating
  task automatic run_op(input logic [31:0] n, input logic [31:0] exp_val, input int exp_cyc,
                        input string tag);
    int cyc;
    bit busy_ok, sub_ok, sub_seen;
    logic err_seen;
    busy_ok = 1'b1; sub_ok = 1'b1; sub_seen = 1'b0; err_seen = 1'b0;
    start_i = 1'b1;
    operand_i = n;
    step();
    start_i = 1'b0;
    operand_i = '0;
    cyc = 1;
    while (1) begin
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      if (dp.alu_op_o === 2'b01) begin
        sub_seen = 1'b1;
        if (dp.we_o !== ~dp.negative_i) sub_ok = 1'b0;
      end
      if (done_o === 1'b1) begin
        err_seen = err_o;
        break;
      end
      if (cyc >= 2000) break;
      step();
      cyc++;
    end
    check({tag, " latency"}, cyc, exp_cyc);
    check({tag, " result"}, dp_out, exp_val);
    check({tag, " err"}, {31'b0, err_seen}, 32'd0);
    check({tag, " busy"}, {31'b0, busy_ok}, 32'd1);
    check({tag, " sub_we"}, {31'b0, sub_ok & sub_seen}, 32'd1);
    step();
    check({tag, " idle"}, {31'b0, busy_o}, 32'd0);
  endtask

  initial begin
    int cyc;
    bit done_seen;

    step();
    step();
    check("rst busy", {31'b0, busy_o}, 32'd0);
    check("rst done_err", {30'b0, done_o, err_o}, 32'd0);
    check("rst ctl", {29'b0, dp.ie_o, dp.we_o, dp.oe_o}, 32'd0);
    check("rst addr_op", {23'b0, dp.addr_wr_o, dp.addr_rda_o, dp.addr_rdb_o}, {30'b0, dp.alu_op_o});
    check("rst data", dp.dp_data_o, 32'd0);
    rst = 1'b0;
    step();

    run_op(32'd16, 32'd4, 21, "n16");
    run_op(32'd0,  32'd0, 9,  "n0");
    run_op(32'd15, 32'd3, 18, "n15");
    run_op(32'd1,  32'd1, 12, "n1");
    run_op(32'd25, 32'd5, 24, "n25");

    // Rejected operand: immediate done+err, no datapath activity
    start_i = 1'b1;
    operand_i = 32'h8000_0000;
    step();
    start_i = 1'b0;
    check("err done_err", {30'b0, done_o, err_o}, 32'd3);
    check("err we_oe", {30'b0, dp.we_o, dp.oe_o}, 32'd0);
    check("err busy", {31'b0, busy_o}, 32'd1);
    step();
    check("err idle", {30'b0, busy_o, done_o}, 32'd0);
    check("err keep result", dp_out, 32'd5);

    // start held high with a new operand mid-run: ignored until IDLE
    start_i = 1'b1;
    operand_i = 32'd100;
    step();
    cyc = 1;
    while (1) begin
      if (cyc == 10) operand_i = 32'd50;
      if (done_o === 1'b1 || cyc >= 2000) break;
      step();
      cyc++;
    end
    check("hold latency", cyc, 39);
    check("hold result", dp_out, 32'd10);
    operand_i = 32'd4;
    step();
    check("hold idle after done", {31'b0, busy_o}, 32'd0);
    step();
    check("hold reaccept", {31'b0, busy_o}, 32'd1);
    start_i = 1'b0;
    cyc = 1;
    while (done_o !== 1'b1 && cyc < 2000) begin
      step();
      cyc++;
    end
    check("hold2 latency", cyc, 15);
    check("hold2 result", dp_out, 32'd2);
    step();

    // Reset in the 15th busy cycle aborts without done_o
    start_i = 1'b1;
    operand_i = 32'd1000;
    step();
    start_i = 1'b0;
    cyc = 1;
    while (cyc < 15) begin
      step();
      cyc++;
    end
    rst = 1'b1;
    step();
    check("abort busy_done", {30'b0, busy_o, done_o}, 32'd0);
    check("abort ctl", {29'b0, dp.ie_o, dp.we_o, dp.oe_o}, 32'd0);
    check("abort addr_op", {21'b0, dp.addr_wr_o, dp.addr_rda_o, dp.addr_rdb_o, dp.alu_op_o}, 32'd0);
    check("abort data", dp.dp_data_o, 32'd0);
    rst = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (done_o === 1'b1 || busy_o === 1'b1) done_seen = 1'b1;
    end
    check("abort no done", {31'b0, done_seen}, 32'd0);

    run_op(32'd9, 32'd3, 18, "n9");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
